// File: rtl/adc_mon_pkg.sv
// ---------------------------------------------------------------------------
// adc_mon_pkg
// Shared constants for the ADC monitoring slice: sample width, default
// accumulator sizing and the averager window-state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package adc_mon_pkg;

    localparam int SMP_W         = 16;
    localparam int MAX_SHIFT_DEF = 7;
    // Wide enough to hold 2^MAX_SHIFT full-scale samples without wrap.
    localparam int ACC_W_DEF     = SMP_W + MAX_SHIFT_DEF;
    localparam int CNT_W         = MAX_SHIFT_DEF + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_DIVIDE  = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

endpackage

// File: rtl/adc_overcurrent_debounce.sv
// ---------------------------------------------------------------------------
// adc_overcurrent_debounce
// Counts consecutive valid samples whose current is strictly above the
// limit and raises a sticky fault once the run length reaches fault_count.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clear          synchronous clear of counter and fault
//   sample_valid   strobe qualifying current
//   current        current sample
//   limit          overcurrent threshold (strictly greater trips)
//   fault_count    run length needed to trip; 0 is treated as 1
//   fault          sticky fault flag
// ---------------------------------------------------------------------------
module adc_overcurrent_debounce
    import adc_mon_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [SMP_W-1:0] current,
    input  logic [SMP_W-1:0] limit,
    input  logic [3:0]       fault_count,
    output logic             fault
);

    logic [3:0] over_cnt;
    logic [3:0] over_cnt_next;
    logic [3:0] threshold;
    logic       over;

    always_comb begin
        over          = (current > limit);
        threshold     = (fault_count == 4'd0) ? 4'd1 : fault_count;
        over_cnt_next = over_cnt;
        if (sample_valid) begin
            if (!over)
                over_cnt_next = 4'd0;
            else if (over_cnt != 4'hF)
                over_cnt_next = over_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            over_cnt <= 4'd0;
            fault    <= 1'b0;
        end else if (clear) begin
            over_cnt <= 4'd0;
            fault    <= 1'b0;
        end else begin
            over_cnt <= over_cnt_next;
            if (sample_valid && over && (over_cnt_next >= threshold))
                fault <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_averager.sv
// ---------------------------------------------------------------------------
// adc_sample_averager
// Windowed mean of ADC voltage/current samples over N = 2^avg_shift samples,
// plus peak-current tracking and debounced overcurrent detection.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   adc_data_valid             one-cycle sample strobe
//   adc_voltage_data/current   16-bit samples
//   avg_shift                  window size exponent, latched per window
//   current_limit, fault_count overcurrent threshold and debounce length
//   stats_clear                synchronous clear of all statistics
//   avg_valid                  one-cycle pulse with new averages
//   avg_voltage, avg_current   windowed means (truncated)
//   peak_current               max current since reset/clear
//   overcurrent_fault          sticky fault flag
// ---------------------------------------------------------------------------
module adc_sample_averager
    import adc_mon_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             adc_data_valid,
    input  logic [SMP_W-1:0] adc_voltage_data,
    input  logic [SMP_W-1:0] adc_current_data,
    input  logic [2:0]       avg_shift,
    input  logic [SMP_W-1:0] current_limit,
    input  logic [3:0]       fault_count,
    input  logic             stats_clear,
    output logic             avg_valid,
    output logic [SMP_W-1:0] avg_voltage,
    output logic [SMP_W-1:0] avg_current,
    output logic [SMP_W-1:0] peak_current,
    output logic             overcurrent_fault
);

    function automatic logic [2:0] clamp_shift(input logic [2:0] sh);
        if (int'(sh) > MAX_SHIFT)
            return 3'(MAX_SHIFT);
        return sh;
    endfunction

    // Mean by power-of-two window: plain right shift, fraction truncated.
    function automatic logic [SMP_W-1:0] trunc_div(input logic [ACC_W-1:0] acc,
                                                   input logic [2:0]       sh);
        logic [ACC_W-1:0] q;
        q = acc >> sh;
        return q[SMP_W-1:0];
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] win_cnt;
    logic [2:0]       shift_lat;
    logic [ACC_W-1:0] acc_v, acc_c;
    logic [ACC_W-1:0] v_ext, c_ext;
    logic [2:0]       win_shift;
    logic [CNT_W-1:0] win_len;
    logic             sample_ok;
    logic             win_close;

    logic [ACC_W-1:0] hold_v_p0, hold_c_p0;
    logic [2:0]       shift_p0;
    logic             vld_p0;
    logic [SMP_W-1:0] div_v_p1, div_c_p1;
    logic             vld_p1;

    assign sample_ok = adc_data_valid & ~stats_clear;
    assign v_ext     = ACC_W'(adc_voltage_data);
    assign c_ext     = ACC_W'(adc_current_data);
    // First sample of a window uses the live avg_shift; later ones the latched copy.
    assign win_shift = (win_cnt == '0) ? clamp_shift(avg_shift) : shift_lat;
    assign win_len   = CNT_W'(1) << win_shift;
    assign win_close = sample_ok && ((win_cnt + CNT_W'(1)) == win_len);

    // ---- accumulate stage ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_v     <= '0;
            acc_c     <= '0;
            win_cnt   <= '0;
            shift_lat <= '0;
        end else if (stats_clear) begin
            acc_v     <= '0;
            acc_c     <= '0;
            win_cnt   <= '0;
            shift_lat <= '0;
        end else if (adc_data_valid) begin
            if (win_cnt == '0)
                shift_lat <= win_shift;
            if (win_close) begin
                acc_v   <= '0;
                acc_c   <= '0;
                win_cnt <= '0;
            end else begin
                acc_v   <= acc_v + v_ext;
                acc_c   <= acc_c + c_ext;
                win_cnt <= win_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else if (stats_clear)
            state <= ST_IDLE;
        else if (win_close)
            state <= ST_DIVIDE;
        else begin
            case (state)
                ST_IDLE:    if (adc_data_valid) state <= ST_ACCUM;
                ST_DIVIDE:  state <= ST_PUBLISH;
                ST_PUBLISH: state <= ST_ACCUM;
                default:    state <= state;
            endcase
        end
    end

    // ---- p0: hold completed window sums ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_v_p0 <= '0;
            hold_c_p0 <= '0;
            shift_p0  <= '0;
            vld_p0    <= 1'b0;
        end else if (stats_clear) begin
            hold_v_p0 <= '0;
            hold_c_p0 <= '0;
            shift_p0  <= '0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= win_close;
            if (win_close) begin
                hold_v_p0 <= acc_v + v_ext;
                hold_c_p0 <= acc_c + c_ext;
                shift_p0  <= win_shift;
            end
        end
    end

    // ---- p1: divide by window length ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_v_p1 <= '0;
            div_c_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (stats_clear) begin
            div_v_p1 <= '0;
            div_c_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                div_v_p1 <= trunc_div(hold_v_p0, shift_p0);
                div_c_p1 <= trunc_div(hold_c_p0, shift_p0);
            end
        end
    end

    // ---- publish ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            avg_voltage <= '0;
            avg_current <= '0;
            avg_valid   <= 1'b0;
        end else if (stats_clear) begin
            avg_voltage <= '0;
            avg_current <= '0;
            avg_valid   <= 1'b0;
        end else begin
            avg_valid <= vld_p1;
            if (vld_p1) begin
                avg_voltage <= div_v_p1;
                avg_current <= div_c_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            peak_current <= '0;
        else if (stats_clear)
            peak_current <= '0;
        else if (adc_data_valid && (adc_current_data > peak_current))
            peak_current <= adc_current_data;
    end

    adc_overcurrent_debounce u_debounce (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (stats_clear),
        .sample_valid (adc_data_valid),
        .current      (adc_current_data),
        .limit        (current_limit),
        .fault_count  (fault_count),
        .fault        (overcurrent_fault)
    );

endmodule

// File: tb/tb_adc_sample_averager.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_averager
// Directed stimulus for adc_sample_averager with a behavioural window model
// compared every cycle, plus hand-computed expectations per scenario.
// ---------------------------------------------------------------------------
module tb_adc_sample_averager;

    logic        clk = 1'b0;
    logic        rstn;
    logic        adc_data_valid;
    logic [15:0] adc_voltage_data;
    logic [15:0] adc_current_data;
    logic [2:0]  avg_shift;
    logic [15:0] current_limit;
    logic [3:0]  fault_count;
    logic        stats_clear;
    logic        avg_valid;
    logic [15:0] avg_voltage;
    logic [15:0] avg_current;
    logic [15:0] peak_current;
    logic        overcurrent_fault;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    adc_sample_averager dut (
        .clk               (clk),
        .rstn              (rstn),
        .adc_data_valid    (adc_data_valid),
        .adc_voltage_data  (adc_voltage_data),
        .adc_current_data  (adc_current_data),
        .avg_shift         (avg_shift),
        .current_limit     (current_limit),
        .fault_count       (fault_count),
        .stats_clear       (stats_clear),
        .avg_valid         (avg_valid),
        .avg_voltage       (avg_voltage),
        .avg_current       (avg_current),
        .peak_current      (peak_current),
        .overcurrent_fault (overcurrent_fault)
    );

    // Behavioural model: a window is a list of N samples whose mean (integer
    // division) appears two clocks after the closing sample.
    int     m_cyc = 0;
    int     m_cnt = 0;
    int     m_n = 1;
    longint m_sv = 0;
    longint m_sc = 0;
    int     m_peak = 0;
    int     m_over = 0;
    int     m_av = 0;
    int     m_ac = 0;
    bit     m_fault = 1'b0;
    bit     m_valid = 1'b0;
    int     pend_v[int];
    int     pend_c[int];

    task automatic model_clear();
        m_cnt = 0; m_sv = 0; m_sc = 0; m_peak = 0; m_over = 0;
        m_fault = 1'b0; m_valid = 1'b0; m_av = 0; m_ac = 0;
        pend_v.delete();
        pend_c.delete();
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_clear();
        end else begin
            m_cyc = m_cyc + 1;
            if (stats_clear) begin
                model_clear();
            end else begin
                if (adc_data_valid) begin
                    if (m_cnt == 0) m_n = 1 << int'(avg_shift);
                    m_sv  = m_sv + longint'(adc_voltage_data);
                    m_sc  = m_sc + longint'(adc_current_data);
                    m_cnt = m_cnt + 1;
                    if (m_cnt == m_n) begin
                        pend_v[m_cyc + 2] = int'(m_sv / longint'(m_n));
                        pend_c[m_cyc + 2] = int'(m_sc / longint'(m_n));
                        m_cnt = 0; m_sv = 0; m_sc = 0;
                    end
                    if (int'(adc_current_data) > m_peak) m_peak = int'(adc_current_data);
                    if (adc_current_data > current_limit) begin
                        if (m_over < 15) m_over = m_over + 1;
                        if (m_over >= ((fault_count == 4'd0) ? 1 : int'(fault_count)))
                            m_fault = 1'b1;
                    end else begin
                        m_over = 0;
                    end
                end
                if (pend_v.exists(m_cyc)) begin
                    m_valid = 1'b1;
                    m_av = pend_v[m_cyc];
                    m_ac = pend_c[m_cyc];
                    pend_v.delete(m_cyc);
                    pend_c.delete(m_cyc);
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_avg_valid", int'(avg_valid), int'(m_valid));
            chk("model_avg_voltage", int'(avg_voltage), m_av);
            chk("model_avg_current", int'(avg_current), m_ac);
            chk("model_peak", int'(peak_current), m_peak);
            chk("model_fault", int'(overcurrent_fault), int'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] v, input logic [15:0] c);
        adc_data_valid   = 1'b1;
        adc_voltage_data = v;
        adc_current_data = c;
        tick();
        adc_data_valid   = 1'b0;
    endtask

    task automatic clear_stats();
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
    endtask

    initial begin
        rstn             = 1'b0;
        adc_data_valid   = 1'b0;
        adc_voltage_data = '0;
        adc_current_data = '0;
        avg_shift        = 3'd0;
        current_limit    = 16'd1000;
        fault_count      = 4'd3;
        stats_clear      = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_avg_voltage", int'(avg_voltage), 0);
        chk("rst_avg_current", int'(avg_current), 0);
        chk("rst_peak", int'(peak_current), 0);
        chk("rst_fault", int'(overcurrent_fault), 0);
        rstn = 1'b1;
        idle(2);

        // Window of four: (100+200+300+401)/4 = 250, (10+20+30+40)/4 = 25
        avg_shift = 3'd2;
        send(16'd100, 16'd10);
        send(16'd200, 16'd20);
        send(16'd300, 16'd30);
        send(16'd401, 16'd40);
        idle(1);
        chk("w4_no_early_valid", int'(avg_valid), 0);
        idle(1);
        chk("w4_valid", int'(avg_valid), 1);
        chk("w4_avg_voltage", int'(avg_voltage), 250);
        chk("w4_avg_current", int'(avg_current), 25);
        idle(1);
        chk("w4_single_pulse", int'(avg_valid), 0);
        chk("w4_avg_holds", int'(avg_voltage), 250);

        // Debounce: run resets on 999, trips on third consecutive 1001
        clear_stats();
        send(16'd0, 16'd1001);
        send(16'd0, 16'd1001);
        send(16'd0, 16'd999);
        send(16'd0, 16'd1001);
        send(16'd0, 16'd1001);
        chk("db_not_yet", int'(overcurrent_fault), 0);
        send(16'd0, 16'd1001);
        chk("db_fault_set", int'(overcurrent_fault), 1);
        chk("db_peak", int'(peak_current), 1001);
        idle(3);

        // Full-scale 128-sample window
        clear_stats();
        avg_shift = 3'd7;
        repeat (128) send(16'hFFFF, 16'hFFFF);
        idle(2);
        chk("fs_valid", int'(avg_valid), 1);
        chk("fs_avg_voltage", int'(avg_voltage), 65535);
        chk("fs_avg_current", int'(avg_current), 65535);
        idle(1);

        // Shift change mid-window: (4+8+12+16)/4 = 10, then N=1
        clear_stats();
        avg_shift = 3'd2;
        send(16'd4, 16'd1);
        send(16'd8, 16'd1);
        avg_shift = 3'd0;
        send(16'd12, 16'd1);
        idle(1);
        chk("sc_window_open", int'(avg_valid), 0);
        send(16'd16, 16'd1);
        idle(2);
        chk("sc_valid", int'(avg_valid), 1);
        chk("sc_avg_voltage", int'(avg_voltage), 10);
        send(16'd7, 16'd2);
        send(16'd9, 16'd3);
        idle(1);
        chk("n1_first_valid", int'(avg_valid), 1);
        chk("n1_first_avg", int'(avg_voltage), 7);
        idle(1);
        chk("n1_second_valid", int'(avg_valid), 1);
        chk("n1_second_avg", int'(avg_voltage), 9);
        chk("n1_second_cur", int'(avg_current), 3);
        idle(1);

        // fault_count=0 trips on one sample; clear beats a coincident sample
        clear_stats();
        avg_shift     = 3'd1;
        fault_count   = 4'd0;
        send(16'd0, 16'd2000);
        chk("fc0_fault", int'(overcurrent_fault), 1);
        adc_data_valid   = 1'b1;
        stats_clear      = 1'b1;
        adc_voltage_data = 16'd0;
        adc_current_data = 16'd5000;
        tick();
        adc_data_valid = 1'b0;
        stats_clear    = 1'b0;
        chk("clr_fault", int'(overcurrent_fault), 0);
        chk("clr_peak", int'(peak_current), 0);
        send(16'd10, 16'd1);
        idle(1);
        chk("clr_window_restart", int'(avg_valid), 0);
        send(16'd30, 16'd3);
        idle(2);
        chk("clr_valid", int'(avg_valid), 1);
        chk("clr_avg_voltage", int'(avg_voltage), 20);
        chk("clr_peak_after", int'(peak_current), 3);
        idle(1);

        // Saturating debounce with the maximum run length
        clear_stats();
        avg_shift     = 3'd0;
        fault_count   = 4'd15;
        current_limit = 16'd100;
        repeat (14) send(16'd1, 16'd200);
        chk("sat_14_no_fault", int'(overcurrent_fault), 0);
        send(16'd1, 16'd200);
        chk("sat_15_fault", int'(overcurrent_fault), 1);
        repeat (3) send(16'd1, 16'd200);
        idle(3);

        // Reset mid-window discards the partial window
        avg_shift     = 3'd2;
        current_limit = 16'd1000;
        fault_count   = 4'd3;
        send(16'd1, 16'd1);
        send(16'd2, 16'd2);
        send(16'd3, 16'd3);
        rstn = 1'b0;
        #2;
        chk("arst_avg_voltage", int'(avg_voltage), 0);
        chk("arst_peak", int'(peak_current), 0);
        chk("arst_fault", int'(overcurrent_fault), 0);
        tick();
        rstn = 1'b1;
        send(16'd8, 16'd1);
        send(16'd8, 16'd1);
        send(16'd8, 16'd1);
        idle(2);
        chk("arst_no_stale_window", int'(avg_valid), 0);
        send(16'd8, 16'd5);
        idle(2);
        chk("arst_valid", int'(avg_valid), 1);
        chk("arst_avg_voltage_new", int'(avg_voltage), 8);
        chk("arst_avg_current_new", int'(avg_current), 2);
        idle(3);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
